// File: rtl/field_pkg.sv
// Shared types and constants for the asteroid field: slot state encoding,
// the fallback LFSR seed and the LFSR step function.
package field_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_FALL    = 2'd2,
    ST_EXPLODE = 2'd3
  } slot_state_e;

  // An all-zero seed would lock the LFSR, so it is replaced by this value.
  localparam logic [15:0] LFSR_ALT_SEED = 16'hACE1;

  // Fibonacci LFSR, taps x^16 + x^14 + x^13 + x^11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/lfsr.sv
// 16-bit free-running LFSR; the seed is loaded while reset is held and the
// register advances on every clock after that.
module lfsr
  import field_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed_i,
  output logic [15:0] rnd_o
);

  logic [15:0] rnd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rnd_q <= (seed_i == 16'd0) ? LFSR_ALT_SEED : seed_i;
    end else begin
      rnd_q <= lfsr_next(rnd_q);
    end
  end

  assign rnd_o = rnd_q;

endmodule

// File: rtl/asteroid_field.sv
// Asteroid field: COUNT independent slots that spawn, wait, fall and explode,
// driven by per-frame pulses and a shared random source.
module asteroid_field
  import field_pkg::*;
#(
  parameter int COUNT          = 8,
  parameter int H_RES          = 640,
  parameter int V_RES          = 480,
  parameter int CORDW          = 16,
  parameter int SPRITE_W       = 32,
  parameter int SPRITE_H       = 32,
  parameter int EXPLODE_FRAMES = 8,
  parameter int MAX_SPEED      = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame,
  input  logic [15:0]                rand_seed,
  input  logic [3:0]                 base_speed,
  input  logic                       hit_valid,
  input  logic [$clog2(COUNT)-1:0]   hit_id,
  output logic                       hit_ready,
  output logic [COUNT*CORDW-1:0]     obj_x,
  output logic [COUNT*CORDW-1:0]     obj_y,
  output logic [COUNT*2-1:0]         obj_state,
  output logic [COUNT-1:0]           obj_visible,
  output logic                       score_pulse,
  output logic                       miss_pulse
);

  localparam int IDW  = $clog2(COUNT);
  localparam int CNTW = $clog2(EXPLODE_FRAMES + 1);
  localparam logic [CNTW-1:0]         CNT_LAST = CNTW'(EXPLODE_FRAMES - 1);
  localparam logic signed [CORDW-1:0] Y_START  = CORDW'(-SPRITE_H);
  localparam logic signed [CORDW-1:0] V_LIM    = CORDW'(V_RES);
  localparam logic signed [CORDW-1:0] SPR_H    = CORDW'(SPRITE_H);
  localparam logic [15:0]             X_SPAN   = 16'(H_RES - SPRITE_W);

  // Hit handshake: a hit is accepted on any cycle with hit_valid & hit_ready;
  // hit_ready is low on frame cycles so hits never race frame updates.
  logic hit_acc;
  assign hit_ready = ~frame;
  assign hit_acc   = hit_valid & ~frame;

  logic [15:0] rnd;

  lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .seed_i (rand_seed),
    .rnd_o  (rnd)
  );

  // Spawn parameters are shared; only the selected slot latches them.
  logic [15:0]             x_mod;
  logic signed [CORDW-1:0] spawn_x;
  logic [4:0]              spd_sum;
  logic [3:0]              spawn_speed;

  assign x_mod       = rnd % X_SPAN;
  assign spawn_x     = $signed(CORDW'(x_mod));
  assign spd_sum     = 5'(base_speed) + 5'(rnd[9:8]);
  assign spawn_speed = (spd_sum > 5'(MAX_SPEED)) ? 4'(MAX_SPEED) : spd_sum[3:0];

  logic [COUNT-1:0] is_idle, spawn_sel, miss_vec, score_vec;

  // Isolate the lowest set bit: only the lowest-index idle slot spawns.
  assign spawn_sel = is_idle & (~is_idle + COUNT'(1));

  for (genvar i = 0; i < COUNT; i++) begin : g_slot
    slot_state_e             state_q, state_d;
    logic signed [CORDW-1:0] x_q, x_d, y_q, y_d, y_next, y_bot;
    logic [3:0]              speed_q, speed_d;
    logic [5:0]              delay_q, delay_d;
    logic [CNTW-1:0]         cnt_q, cnt_d;
    logic                    hit_me, miss_s, score_s, vis_s;

    assign y_next = y_q + $signed({{(CORDW-4){1'b0}}, speed_q});
    assign y_bot  = y_q + SPR_H;
    assign hit_me = hit_acc && (hit_id == IDW'(i));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= ST_IDLE;
        x_q     <= '0;
        y_q     <= Y_START;
        speed_q <= '0;
        delay_q <= '0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        x_q     <= x_d;
        y_q     <= y_d;
        speed_q <= speed_d;
        delay_q <= delay_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      speed_d = speed_q;
      delay_d = delay_q;
      cnt_d   = cnt_q;
      miss_s  = 1'b0;
      score_s = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame && spawn_sel[i]) begin
            state_d = ST_WAIT;
            delay_d = rnd[5:0];
            x_d     = spawn_x;
            y_d     = Y_START;
            speed_d = spawn_speed;
            cnt_d   = '0;
          end
        end
        ST_WAIT: begin
          if (frame) begin
            if (delay_q == 6'd0) state_d = ST_FALL;
            else delay_d = delay_q - 6'd1;
          end
        end
        ST_FALL: begin
          if (hit_me) begin
            state_d = ST_EXPLODE;
            cnt_d   = '0;
            score_s = 1'b1;
          end else if (frame) begin
            if (y_next > V_LIM) begin
              state_d = ST_IDLE;
              miss_s  = 1'b1;
            end else begin
              y_d = y_next;
            end
          end
        end
        ST_EXPLODE: begin
          if (frame) begin
            if (cnt_q == CNT_LAST) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNTW'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    always_comb begin
      vis_s = 1'b0;
      if ((state_q == ST_FALL || state_q == ST_EXPLODE) && !y_bot[CORDW-1] && (y_bot != '0))
        vis_s = 1'b1;
    end

    assign is_idle[i]                 = (state_q == ST_IDLE);
    assign miss_vec[i]                = miss_s;
    assign score_vec[i]               = score_s;
    assign obj_x[i*CORDW +: CORDW]    = x_q;
    assign obj_y[i*CORDW +: CORDW]    = y_q;
    assign obj_state[2*i +: 2]        = state_q;
    assign obj_visible[i]             = vis_s;
  end

  logic score_q, miss_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_q <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      score_q <= |score_vec;
      miss_q  <= |miss_vec;
    end
  end

  assign score_pulse = score_q;
  assign miss_pulse  = miss_q;

endmodule

// File: tb/tb_asteroid_field.sv
// Bench for asteroid_field: a frame-level behavioural model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_asteroid_field;

  localparam int COUNT = 8;
  localparam int CORDW = 16;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int SPR_W = 32;
  localparam int SPR_H = 32;
  localparam int EXPL  = 8;
  localparam int MAXSP = 7;

  logic                   clk;
  logic                   rst;
  logic                   frame;
  logic [15:0]            rand_seed;
  logic [3:0]             base_speed;
  logic                   hit_valid;
  logic [2:0]             hit_id;
  logic                   hit_ready;
  logic [COUNT*CORDW-1:0] obj_x, obj_y;
  logic [COUNT*2-1:0]     obj_state;
  logic [COUNT-1:0]       obj_visible;
  logic                   score_pulse, miss_pulse;

  asteroid_field #(
    .COUNT(COUNT), .H_RES(H_RES), .V_RES(V_RES), .CORDW(CORDW),
    .SPRITE_W(SPR_W), .SPRITE_H(SPR_H), .EXPLODE_FRAMES(EXPL), .MAX_SPEED(MAXSP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame       (frame),
    .rand_seed   (rand_seed),
    .base_speed  (base_speed),
    .hit_valid   (hit_valid),
    .hit_id      (hit_id),
    .hit_ready   (hit_ready),
    .obj_x       (obj_x),
    .obj_y       (obj_y),
    .obj_state   (obj_state),
    .obj_visible (obj_visible),
    .score_pulse (score_pulse),
    .miss_pulse  (miss_pulse)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 60) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [31:0] d_state(input int i);
    return 32'(obj_state[2*i +: 2]);
  endfunction
  function automatic logic signed [31:0] d_x(input int i);
    return 32'($signed(obj_x[i*CORDW +: CORDW]));
  endfunction
  function automatic logic signed [31:0] d_y(input int i);
    return 32'($signed(obj_y[i*CORDW +: CORDW]));
  endfunction

  // ---------------- behavioural model ----------------
  // States: 0 idle, 1 waiting, 2 falling, 3 exploding.
  int          m_state[COUNT];
  int          m_x[COUNT], m_y[COUNT], m_spd[COUNT], m_dly[COUNT], m_cnt[COUNT];
  int          m_score, m_miss;
  logic [15:0] m_lfsr;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int i = 0; i < COUNT; i++) begin
          m_state[i] = 0; m_x[i] = 0; m_y[i] = -SPR_H;
          m_spd[i] = 0; m_dly[i] = 0; m_cnt[i] = 0;
        end
        m_score = 0;
        m_miss  = 0;
        m_lfsr  = (rand_seed == 16'd0) ? 16'hACE1 : rand_seed;
      end else begin
        automatic int  r      = int'(m_lfsr);
        automatic bit  taken  = 1'b0;
        automatic int  sc     = 0;
        automatic int  mi     = 0;
        automatic bit  acc    = hit_valid && !frame;
        for (int i = 0; i < COUNT; i++) begin
          case (m_state[i])
            0: if (frame && !taken) begin
              taken      = 1'b1;
              m_state[i] = 1;
              m_dly[i]   = r % 64;
              m_x[i]     = r % (H_RES - SPR_W);
              m_y[i]     = -SPR_H;
              m_spd[i]   = int'(base_speed) + ((r / 256) % 4);
              if (m_spd[i] > MAXSP) m_spd[i] = MAXSP;
              m_cnt[i]   = 0;
            end
            1: if (frame) begin
              if (m_dly[i] == 0) m_state[i] = 2;
              else m_dly[i] = m_dly[i] - 1;
            end
            2: if (acc && int'(hit_id) == i) begin
              m_state[i] = 3;
              m_cnt[i]   = 0;
              sc         = 1;
            end else if (frame) begin
              if (m_y[i] + m_spd[i] > V_RES) begin
                m_state[i] = 0;
                mi         = 1;
              end else begin
                m_y[i] = m_y[i] + m_spd[i];
              end
            end
            default: if (frame) begin
              m_cnt[i] = m_cnt[i] + 1;
              if (m_cnt[i] == EXPL) begin
                m_state[i] = 0;
                m_cnt[i]   = 0;
              end
            end
          endcase
        end
        m_score = sc;
        m_miss  = mi;
        m_lfsr  = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < COUNT; i++) begin
          automatic int vis = ((m_state[i] >= 2) && (m_y[i] + SPR_H > 0)) ? 1 : 0;
          check($sformatf("model state[%0d]", i), d_state(i), m_state[i]);
          check($sformatf("model x[%0d]", i), d_x(i), m_x[i]);
          check($sformatf("model y[%0d]", i), d_y(i), m_y[i]);
          check($sformatf("model visible[%0d]", i), 32'(obj_visible[i]), vis);
        end
        check("model score_pulse", 32'(score_pulse), m_score);
        check("model miss_pulse", 32'(miss_pulse), m_miss);
        check("model hit_ready", 32'(hit_ready), frame ? 0 : 1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    frame = 1'b1;
    step();
    frame = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic reset_with(input logic [15:0] seed);
    rand_seed = seed;
    rst       = 1'b0;
    step();
    step();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst        = 1'b1;
    frame      = 1'b0;
    rand_seed  = 16'd0;
    base_speed = 4'd4;
    hit_valid  = 1'b0;
    hit_id     = 3'd0;
    #2;

    // Phase A: zero seed falls back to 16'hACE1.
    reset_with(16'd0);
    step();
    for (int i = 0; i < COUNT; i++) begin
      check($sformatf("reset state[%0d]", i), d_state(i), 0);
      check($sformatf("reset y[%0d]", i), d_y(i), -32);
    end
    check("reset score_pulse", 32'(score_pulse), 0);
    check("reset miss_pulse", 32'(miss_pulse), 0);

    // First frame right after release uses rnd = 0xACE1: x = 44257 % 608 = 481.
    rst   = 1'b1;
    frame = 1'b1;
    step();
    frame = 1'b0;
    check("spawn1 state[0]", d_state(0), 1);
    check("spawn1 x[0]", d_x(0), 481);
    check("spawn1 state[1]", d_state(1), 0);
    step();
    step();
    step();

    // One spawn per frame, lowest index first, x within 0..607.
    for (int k = 2; k <= COUNT; k++) begin
      frame_pulse();
      check($sformatf("spawn%0d new slot busy", k), (d_state(k-1) != 0) ? 1 : 0, 1);
      check($sformatf("spawn%0d x range", k),
            (d_x(k-1) >= 0 && d_x(k-1) <= 607) ? 1 : 0, 1);
      if (k < COUNT) check($sformatf("spawn%0d next idle", k), d_state(k), 0);
    end

    // Hit on a waiting slot is ignored (slot 0 delay is 33).
    hit_valid = 1'b1;
    hit_id    = 3'd0;
    check("ready off-frame", 32'(hit_ready), 1);
    step();
    hit_valid = 1'b0;
    check("wait-hit score", 32'(score_pulse), 0);
    check("wait-hit state[0]", d_state(0), 1);
    step();

    // Phase B: seed 0x1C40 gives delay 0, x 544, speed 4 on slot 0.
    reset_with(16'h1C40);
    rst   = 1'b1;
    frame = 1'b1;
    step();
    frame = 1'b0;
    check("fallB spawn state[0]", d_state(0), 1);
    check("fallB spawn x[0]", d_x(0), 544);
    step();
    step();
    step();
    frame_pulse();
    check("fallB f2 state[0]", d_state(0), 2);
    check("fallB f2 y[0]", d_y(0), -32);
    check("fallB f2 visible[0]", 32'(obj_visible[0]), 0);
    frame_pulse();
    check("fallB f3 y[0]", d_y(0), -28);
    check("fallB f3 visible[0]", 32'(obj_visible[0]), 1);
    for (int f = 4; f <= 130; f++) frame_pulse();
    check("fallB y at bottom edge", d_y(0), 480);
    check("fallB still falling", d_state(0), 2);
    frame = 1'b1;
    step();
    frame = 1'b0;
    check("miss state[0]", d_state(0), 0);
    check("miss pulse high", 32'(miss_pulse), 1);
    step();
    check("miss pulse one cycle", 32'(miss_pulse), 0);
    step();
    step();

    // Phase C: hit coincident with a frame is held off one cycle.
    reset_with(16'h1C40);
    rst   = 1'b1;
    frame = 1'b1;
    step();
    frame = 1'b0;
    step();
    step();
    step();
    frame_pulse();
    frame_pulse();
    check("hitC pre y[0]", d_y(0), -28);
    frame     = 1'b1;
    hit_valid = 1'b1;
    hit_id    = 3'd0;
    #1;
    check("ready on frame", 32'(hit_ready), 0);
    step();
    frame = 1'b0;
    check("frame-hit not taken", d_state(0), 2);
    check("frame-hit y[0]", d_y(0), -24);
    check("frame-hit no score", 32'(score_pulse), 0);
    step();
    hit_valid = 1'b0;
    check("hit state[0]", d_state(0), 3);
    check("hit score pulse", 32'(score_pulse), 1);
    step();
    check("score one cycle", 32'(score_pulse), 0);
    hit_valid = 1'b1;
    step();
    hit_valid = 1'b0;
    check("second hit no score", 32'(score_pulse), 0);
    check("second hit state", d_state(0), 3);
    for (int f = 1; f <= 7; f++) frame_pulse();
    check("explode after 7", d_state(0), 3);
    check("explode y frozen", d_y(0), -24);
    frame_pulse();
    check("explode after 8", d_state(0), 0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
